// File: rtl/cpu_mu0_core.sv
// MU0 architectural state and execute unit: accumulator, 12-bit PC and run flag.
// Optional OUT trace print enabled by defining MU0_CORE_OUT_DISPLAY_EN.
module cpu_mu0_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic [15:0] readdata,
    input  logic        validRead,
    output logic [11:0] pc,
    output logic [15:0] writedata,
    output logic        running
);

    typedef enum logic [3:0] {
        OP_LDA = 4'd0,
        OP_STO = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_JMP = 4'd4,
        OP_JGE = 4'd5,
        OP_JNE = 4'd6,
        OP_STP = 4'd7,
        OP_OUT = 4'd8
    } mu0_op_e;

    logic [15:0] r_acc;
    logic [11:0] r_pc;
    logic        r_run;

    logic [15:0] w_acc_nxt;
    logic [11:0] w_pc_nxt;
    logic        w_run_nxt;
    logic [3:0]  w_opcode;
    logic [11:0] w_operand;
    logic [11:0] w_pc_inc;
    logic        w_exec;
    logic        w_acc_neg;
    logic        w_acc_zero;

    assign w_opcode   = instr[15:12];
    assign w_operand  = instr[11:0];
    assign w_pc_inc   = r_pc + 12'd1;
    assign w_exec     = validRead & r_run;
    assign w_acc_neg  = r_acc[15];
    assign w_acc_zero = (r_acc == 16'h0000);

    // Instruction decode and next architectural state; holds everything when not executing.
    always_comb begin
        w_acc_nxt = r_acc;
        w_pc_nxt  = r_pc;
        w_run_nxt = r_run;
        if (w_exec) begin
            case (w_opcode)
                OP_LDA: begin
                    w_acc_nxt = readdata;
                    w_pc_nxt  = w_pc_inc;
                end
                OP_STO: begin
                    w_pc_nxt  = w_pc_inc;
                end
                OP_ADD: begin
                    w_acc_nxt = r_acc + readdata;
                    w_pc_nxt  = w_pc_inc;
                end
                OP_SUB: begin
                    w_acc_nxt = r_acc - readdata;
                    w_pc_nxt  = w_pc_inc;
                end
                OP_JMP: begin
                    w_pc_nxt  = w_operand;
                end
                OP_JGE: begin
                    if (!w_acc_neg) begin
                        w_pc_nxt = w_operand;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
                OP_JNE: begin
                    if (!w_acc_zero) begin
                        w_pc_nxt = w_operand;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
                OP_STP: begin
                    w_run_nxt = 1'b0;
                end
                OP_OUT: begin
                    w_pc_nxt  = w_pc_inc;
                end
                default: begin
                    w_pc_nxt  = w_pc_inc;
                end
            endcase
        end else begin
            w_acc_nxt = r_acc;
            w_pc_nxt  = r_pc;
            w_run_nxt = r_run;
        end
    end

    // Architectural registers; asynchronous reset restarts the core at address zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= 16'h0000;
            r_pc  <= 12'h000;
            r_run <= 1'b1;
        end else begin
            r_acc <= w_acc_nxt;
            r_pc  <= w_pc_nxt;
            r_run <= w_run_nxt;
        end
    end

`ifdef MU0_CORE_OUT_DISPLAY_EN
    // Simulation trace of the signed accumulator when OUT executes.
    always @(posedge clk) begin
        if (rst && w_exec && (w_opcode == OP_OUT)) begin
            $display("CPU : OUTPUT: %d", $signed(r_acc));
        end
    end
`endif

    assign pc        = r_pc;
    assign writedata = r_acc;
    assign running   = r_run;

endmodule

// File: tb/tb_cpu_mu0_core.sv
// Scoreboard bench for cpu_mu0_core: directed scenarios followed by random instruction streams.
module tb_cpu_mu0_core;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic [15:0] readdata;
    logic        validRead;
    logic [11:0] pc;
    logic [15:0] writedata;
    logic        running;

    cpu_mu0_core dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .readdata  (readdata),
        .validRead (validRead),
        .pc        (pc),
        .writedata (writedata),
        .running   (running)
    );

    typedef struct {
        logic [11:0] pc;
        logic [15:0] acc;
        logic        run;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [15:0] m_acc;
    logic [11:0] m_pc;
    logic        m_run;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: architectural effect of one clock edge.
    task automatic model_edge(input logic r, input logic v, input logic [15:0] ins, input logic [15:0] rd);
        int op;
        int s;
        op = int'(ins[15:12]);
        s  = int'(ins[11:0]);
        if (!r) begin
            m_acc = 16'h0000;
            m_pc  = 12'h000;
            m_run = 1'b1;
        end else if (v && m_run) begin
            if (op == 0)      begin m_acc = rd;                        m_pc = 12'((int'(m_pc) + 1) % 4096); end
            else if (op == 2) begin m_acc = 16'((int'(m_acc) + int'(rd)) % 65536); m_pc = 12'((int'(m_pc) + 1) % 4096); end
            else if (op == 3) begin m_acc = 16'((int'(m_acc) - int'(rd) + 65536) % 65536); m_pc = 12'((int'(m_pc) + 1) % 4096); end
            else if (op == 4) begin m_pc = 12'(s); end
            else if (op == 5) begin m_pc = ($signed(m_acc) >= 0) ? 12'(s) : 12'((int'(m_pc) + 1) % 4096); end
            else if (op == 6) begin m_pc = (m_acc != 16'h0000) ? 12'(s) : 12'((int'(m_pc) + 1) % 4096); end
            else if (op == 7) begin m_run = 1'b0; end
            else              begin m_pc = 12'((int'(m_pc) + 1) % 4096); end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [15:0] ins, input logic [15:0] rd, input string tag);
        exp_t e;
        @(negedge clk);
        rst       = r;
        validRead = v;
        instr     = ins;
        readdata  = rd;
        model_edge(r, v, ins, rd);
        e.pc  = m_pc;
        e.acc = m_acc;
        e.run = m_run;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    function automatic logic [15:0] mk(input int op, input int s);
        logic [15:0] w;
        w = {4'(op), 12'(s)};
        return w;
    endfunction

    // Monitor: compares the registered outputs after each edge against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            cmp({e.tag, ".pc"},  {4'h0, pc},        {4'h0, e.pc});
            cmp({e.tag, ".acc"}, writedata,         e.acc);
            cmp({e.tag, ".run"}, {15'h0000, running}, {15'h0000, e.run});
        end
    end

    initial begin
        rst       = 1'b0;
        validRead = 1'b0;
        instr     = 16'h0000;
        readdata  = 16'h0000;
        m_acc     = 16'h0000;
        m_pc      = 12'h000;
        m_run     = 1'b1;

        // Strobes while reset is held must not change anything.
        step(1'b0, 1'b1, mk(0, 16'h010), 16'h1234, "rst_hold_lda");
        step(1'b0, 1'b1, mk(4, 12'h0ab), 16'h0000, "rst_hold_jmp");
        step(1'b0, 1'b1, mk(7, 0),       16'h0000, "rst_hold_stp");

        step(1'b1, 1'b1, mk(0, 12'h010), 16'h0005, "lda5");
        step(1'b1, 1'b1, mk(2, 12'h011), 16'h0003, "add3");
        step(1'b1, 1'b1, mk(3, 12'h012), 16'h0009, "sub9");
        step(1'b1, 1'b1, mk(1, 12'h013), 16'h7777, "sto");
        step(1'b1, 1'b1, mk(2, 12'h014), 16'h0002, "add_wrap");
        step(1'b1, 1'b1, mk(0, 12'h015), 16'hFFFF, "lda_neg");
        step(1'b1, 1'b1, mk(5, 12'h123), 16'h0000, "jge_not_taken");
        step(1'b1, 1'b1, mk(0, 12'h016), 16'h0000, "lda0");
        step(1'b1, 1'b1, mk(5, 12'h123), 16'h0000, "jge_taken");
        step(1'b1, 1'b1, mk(6, 12'h456), 16'h0000, "jne_not_taken");
        step(1'b1, 1'b1, mk(0, 12'h017), 16'h0001, "lda1");
        step(1'b1, 1'b1, mk(6, 12'h456), 16'h0000, "jne_taken");
        step(1'b1, 1'b1, mk(4, 12'hFFF), 16'h0000, "jmp_fff");
        step(1'b1, 1'b1, mk(0, 12'h018), 16'h4321, "lda_pc_wrap");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 16'($urandom), 16'($urandom), "idle");
        end
        step(1'b1, 1'b1, mk(0, 12'h019), 16'h0007, "lda7");
        step(1'b1, 1'b1, mk(8, 12'h000), 16'h5555, "out");
        step(1'b1, 1'b1, mk(12, 12'h000), 16'h5555, "nop12");
        step(1'b1, 1'b1, mk(7, 12'h000), 16'h0000, "stp");
        step(1'b1, 1'b1, mk(0, 12'h020), 16'hBEEF, "halted_lda");
        step(1'b1, 1'b1, mk(4, 12'h020), 16'hBEEF, "halted_jmp");

        // Asynchronous reset must act between clock edges.
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        cmp("async_rst.pc",  {4'h0, pc},          16'h0000);
        cmp("async_rst.acc", writedata,           16'h0000);
        cmp("async_rst.run", {15'h0000, running}, 16'h0001);
        model_edge(1'b0, 1'b0, 16'h0000, 16'h0000);
        step(1'b0, 1'b1, mk(0, 0), 16'h1111, "async_rst_hold");
        step(1'b1, 1'b1, mk(0, 0), 16'h2222, "post_rst_lda");

        // Random instruction streams with occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic r;
            logic v;
            r = !(($urandom_range(0, 60) == 0) || (!m_run && $urandom_range(0, 3) == 0));
            v = ($urandom_range(0, 3) != 0);
            step(r, v, 16'($urandom), 16'($urandom), "rand");
        end

        // Let the monitor drain the scoreboard, bounded.
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_mu0_core.md
# cpu_mu0_core

Architectural-state and execute block of the MU0 processor. It holds the accumulator, the 12-bit program counter and the run flag, and executes one instruction per `validRead` strobe. The enclosing sequencer owns fetch/exec states, the memory bus and instruction latching. The core sees only the current instruction word, the memory read data and a strobe marking the execute cycle.

## Interface
Parameters: none.

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `instr`  in  16  current instruction; `[15:12]` opcode, `[11:0]` operand address S
- `readdata`  in  16  memory read data; operand for LDA/ADD/SUB when `validRead`=1
- `validRead`  in  1  execute strobe: the instruction in `instr` is executed on this clock edge
- `pc`  out  12  program counter (fetch address)
- `writedata`  out  16  accumulator value; the sequencer stores it to memory for STO
- `running`  out  1  1 = executing, 0 = halted by STP

## Operation
- Registers: ACC[15:0], PC[11:0], RUN. `writedata` = ACC, `pc` = PC, `running` = RUN (direct register outputs).
- Nothing changes when `validRead`=0 or RUN=0. In those cases `instr` and `readdata` are ignored.
- When `validRead`=1 and RUN=1, decode `instr[15:12]`:
  - 0 LDA: ACC←readdata; PC←PC+1
  - 1 STO: ACC unchanged; PC←PC+1. The memory write is the sequencer's job.
  - 2 ADD: ACC←(ACC+readdata) mod 2^16; PC←PC+1
  - 3 SUB: ACC←(ACC−readdata) mod 2^16; PC←PC+1
  - 4 JMP: PC←S
  - 5 JGE: PC←S if ACC[15]=0 (signed ≥0), else PC+1
  - 6 JNE: PC←S if ACC≠0, else PC+1
  - 7 STP: RUN←0; PC and ACC unchanged
  - 8 OUT: PC←PC+1; ACC unchanged; emits a trace if configured
  - 9–15: no-op, PC←PC+1
- Arithmetic: 16-bit two's complement. No carry or overflow flags; overflow wraps silently.
- PC increment wraps 0xFFF→0x000.
- Jump conditions use ACC before the edge.
- A halted core stays halted until reset. No instruction re-enables RUN.

## Timing
- Reset (`rst`=0, asynchronous): ACC=0x0000, PC=0x000, RUN=1, applied immediately and held while `rst` is low. On release, the first `validRead` edge executes normally.
- Reset during execution: state is cleared immediately. Any in-progress strobe is lost.
- Latency: one cycle. Updates are visible on outputs right after the `validRead` edge.
- The sequencer samples `pc` for the next fetch and `writedata` for STO in the cycle after the update.
- `validRead` is asserted in the cycle where `readdata` holds the operand:
  - 3-cycle ops (LDA/ADD/SUB): EXEC2
  - all others: EXEC1
- The core requires at most one strobe per instruction. Back-to-back strobes each execute.

## Configuration
- `MU0_CORE_OUT_DISPLAY_EN` defined: OUT executes a simulation print "CPU : OUTPUT: %d" of the signed ACC value at the execute edge.
- Undefined: OUT is a pure PC+1 no-op. Register behaviour is identical either way.

## Test plan
- Reset → PC=0x000, ACC=0x0000, RUN=1. Strobes with `rst`=0 cause no change.
- LDA 0x010 with readdata=0x0005, then ADD with readdata=0x0003, then SUB with readdata=0x0009 → writedata 0x0005, 0x0008, 0xFFFF; PC 1, 2, 3.
- ADD wrap: ACC=0xFFFF, ADD 0x0002 → ACC=0x0001.
- Branches:
  - ACC=0xFFFF: JGE 0x123 → PC=PC+1.
  - ACC=0x0000: JGE 0x123 → PC=0x123; then JNE 0x456 → PC=0x124.
  - JMP 0xFFF then LDA → PC=0x000.
- STP → running=0. Later strobes with LDA leave ACC/PC unchanged. Async reset restores running=1, PC=0.
- `validRead`=0 with varying instr/readdata for 10 cycles → no output change. OUT with ACC=0x0007 → PC+1, ACC unchanged, print only with the macro defined.
